// File: rtl/regfile_write_arbiter_if.sv
// Requester and register-file write-port signals of the write arbiter.
// master: requesters plus register-file side; slave: the arbiter.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              req0;
  logic              req1;
  logic              last0;
  logic              last1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              ack0;
  logic              ack1;
  logic              WriteEn;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;

  modport master (
    output req0, req1, last0, last1, addr0, addr1, data0, data1,
    input  ack0, ack1, WriteEn, WriteReg, WriteData
  );

  modport slave (
    input  req0, req1, last0, last1, addr0, addr1, data0, data1,
    output ack0, ack1, WriteEn, WriteReg, WriteData
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two
// burst requesters; the winning beat is registered onto WriteEn/WriteReg/WriteData.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  regfile_write_arbiter_if.slave   bus,
  output logic                     busy,
  output logic                     owner,
  output logic [7:0]               wr_count
);

  localparam int unsigned BEAT_W = 4;
  localparam int unsigned WRC_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                owner_q, owner_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WRC_W-1:0]    wr_count_q, wr_count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                ack0_c, ack1_c;
  logic                cur_sel;
  logic                cur_req;
  logic                cur_last;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_data;
  logic [BEAT_W-1:0]   beat_inc;

  // State and write-port registers; reset drops WriteEn without an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      beat_cnt_q <= '0;
      wr_count_q <= '0;
      we_q       <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      wr_count_q <= wr_count_d;
      we_q       <= we_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state, grant bookkeeping and write-port capture.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    wr_count_d = wr_count_q;
    we_d       = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    ack0_c     = 1'b0;
    ack1_c     = 1'b0;

    cur_sel  = (state_q == ST_GRANT1);
    cur_req  = cur_sel ? bus.req1  : bus.req0;
    cur_last = cur_sel ? bus.last1 : bus.last0;
    cur_addr = cur_sel ? bus.addr1 : bus.addr0;
    cur_data = cur_sel ? bus.data1 : bus.data0;
    beat_inc = beat_cnt_q + BEAT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        // Both requesting: ptr decides; otherwise the lone requester wins.
        if (bus.req0 && (!bus.req1 || !ptr_q)) begin
          state_d    = ST_GRANT0;
          owner_d    = 1'b0;
          beat_cnt_d = '0;
        end else if (bus.req1) begin
          state_d    = ST_GRANT1;
          owner_d    = 1'b1;
          beat_cnt_d = '0;
        end
      end

      ST_GRANT0, ST_GRANT1: begin
        ack0_c = (state_q == ST_GRANT0) && bus.req0;
        ack1_c = (state_q == ST_GRANT1) && bus.req1;
        if (cur_req) begin
          we_d       = 1'b1;
          wreg_d     = cur_addr;
          wdata_d    = cur_data;
          beat_cnt_d = beat_inc;
          wr_count_d = wr_count_q + WRC_W'(1);
          // Burst ends on last beat or when the beat budget is used up.
          if (cur_last || (beat_inc == BEAT_W'(MAX_BURST))) begin
            state_d = ST_IDLE;
            ptr_d   = ~cur_sel;
          end
        end else begin
          state_d = ST_IDLE;
          ptr_d   = ~cur_sel;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ack0      = ack0_c;
  assign bus.ack1      = ack1_c;
  assign bus.WriteEn   = we_q;
  assign bus.WriteReg  = wreg_q;
  assign bus.WriteData = wdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign owner         = owner_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: requesters are fed from beat queues and the observed
// write-port stream is compared against a burst-level round-robin model.
module tb_regfile_write_arbiter;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned MAX_BURST = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic       owner;
  logic [7:0] wr_count;

  regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .owner(owner), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              own;
    logic [7:0]        cnt;
  } exp_t;

  beat_t q0[$];
  beat_t q1[$];
  exp_t  exp_q[$];
  int    n_assert = 0;
  int    n_fail = 0;
  bit    m_ptr = 1'b0;
  int    m_total = 0;
  logic  s0, s1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    if (q0.size() != 0) begin
      bus.req0 = 1'b1; bus.addr0 = q0[0].addr; bus.data0 = q0[0].data; bus.last0 = q0[0].last;
    end else begin
      bus.req0 = 1'b0; bus.last0 = 1'b0;
    end
    if (q1.size() != 0) begin
      bus.req1 = 1'b1; bus.addr1 = q1[0].addr; bus.data1 = q1[0].data; bus.last1 = q1[0].last;
    end else begin
      bus.req1 = 1'b0; bus.last1 = 1'b0;
    end
  endtask

  // One clock: sample acks mid-cycle, retire accepted beats after the edge.
  task automatic advance();
    @(negedge clk);
    s0 = bus.ack0;
    s1 = bus.ack1;
    chk("ack_exclusive", 32'(s0 & s1), 32'(0));
    @(posedge clk);
    #1;
    if (s0 && q0.size() != 0) void'(q0.pop_front());
    if (s1 && q1.size() != 0) void'(q1.pop_front());
    drive();
  endtask

  // Burst-level model: pick a requester by round robin, take beats until
  // last, MAX_BURST or the requester runs dry; each grant is followed by
  // one idle cycle, plus one more when the requester withdrew.
  task automatic build_model();
    beat_t c0[$];
    beat_t c1[$];
    exp_t  e;
    c0 = q0;
    c1 = q1;
    exp_q.delete();
    e = '0;
    exp_q.push_back(e);
    while (c0.size() != 0 || c1.size() != 0) begin
      bit sel;
      int n;
      bit done;
      bit withdrew;
      beat_t b;
      if (c0.size() != 0 && c1.size() != 0) sel = m_ptr;
      else sel = (c1.size() != 0);
      n = 0; done = 1'b0; withdrew = 1'b0;
      while (!done) begin
        b = sel ? c1.pop_front() : c0.pop_front();
        n++;
        m_total++;
        e = '0;
        e.we = 1'b1; e.addr = b.addr; e.data = b.data; e.own = sel; e.cnt = 8'(m_total);
        exp_q.push_back(e);
        if (b.last || n == int'(MAX_BURST)) done = 1'b1;
        else if ((sel ? c1.size() : c0.size()) == 0) begin
          done = 1'b1; withdrew = 1'b1;
        end
      end
      e = '0;
      exp_q.push_back(e);
      if (withdrew) exp_q.push_back(e);
      m_ptr = ~sel;
    end
  endtask

  task automatic run_scenario(input string name);
    @(posedge clk);
    #1;
    build_model();
    drive();
    foreach (exp_q[i]) begin
      advance();
      chk({name, ".we"}, 32'(bus.WriteEn), 32'(exp_q[i].we));
      if (exp_q[i].we) begin
        chk({name, ".reg"},   32'(bus.WriteReg),  32'(exp_q[i].addr));
        chk({name, ".data"},  32'(bus.WriteData), 32'(exp_q[i].data));
        chk({name, ".owner"}, 32'(owner),         32'(exp_q[i].own));
        chk({name, ".count"}, 32'(wr_count),      32'(exp_q[i].cnt));
      end
    end
    chk({name, ".busy_end"}, 32'(busy), 32'(0));
    chk({name, ".drained"}, 32'(q0.size() + q1.size()), 32'(0));
  endtask

  task automatic push_beat(input bit who, input int a, input int d, input bit l);
    beat_t b;
    b.addr = ADDR_W'(a);
    b.data = DATA_W'(d);
    b.last = l;
    if (who) q1.push_back(b);
    else q0.push_back(b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rem;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.last0 = 1'b0; bus.last1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.data0 = '0; bus.data1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.we",    32'(bus.WriteEn),   32'(0));
    chk("rst.reg",   32'(bus.WriteReg),  32'(0));
    chk("rst.data",  32'(bus.WriteData), 32'(0));
    chk("rst.busy",  32'(busy),          32'(0));
    chk("rst.owner", 32'(owner),         32'(0));
    chk("rst.count", 32'(wr_count),      32'(0));
    chk("rst.ack",   32'({bus.ack0, bus.ack1}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single 8-beat burst from requester 0.
    for (int i = 0; i < 8; i++) push_beat(1'b0, i, i, i == 7);
    run_scenario("single");
    chk("single.total", 32'(wr_count), 32'(8));

    // Reset asserted mid-burst clears outputs without a clock edge.
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push_beat(1'b0, i, 16'h0100 + i, i == 7);
    drive();
    repeat (3) advance();
    chk("midrst.pre_we",  32'(bus.WriteEn), 32'(1));
    chk("midrst.pre_ack", 32'(bus.ack0),    32'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.we",    32'(bus.WriteEn), 32'(0));
    chk("midrst.ack",   32'({bus.ack0, bus.ack1}), 32'(0));
    chk("midrst.busy",  32'(busy),        32'(0));
    chk("midrst.count", 32'(wr_count),    32'(0));
    chk("midrst.owner", 32'(owner),       32'(0));
    q0.delete();
    drive();
    m_ptr = 1'b0;
    m_total = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst.busy", 32'(busy), 32'(0));

    // Contention: both rise together, requester 0 first.
    push_beat(1'b0, 1, 16'h00AA, 1'b0);
    push_beat(1'b0, 2, 16'h00BB, 1'b1);
    push_beat(1'b1, 3, 16'h1111, 1'b0);
    push_beat(1'b1, 4, 16'h2222, 1'b1);
    run_scenario("contend");

    // Single beat from requester 0 hands priority to requester 1.
    push_beat(1'b0, 5, 16'h5555, 1'b1);
    run_scenario("prime");

    // Forced release: 12-beat requester-1 burst with requester 0 waiting.
    for (int i = 0; i < 12; i++) push_beat(1'b1, i % 8, 16'h1000 + i, i == 11);
    push_beat(1'b0, 6, 16'hA006, 1'b0);
    push_beat(1'b0, 7, 16'hA007, 1'b1);
    run_scenario("forced");

    // Withdrawal after 3 beats without last.
    for (int i = 0; i < 3; i++) push_beat(1'b0, 2 * i, 16'hC000 + i, 1'b0);
    run_scenario("withdraw");

    // Priority left at requester 1 by the withdrawal.
    push_beat(1'b0, 0, 16'hD000, 1'b1);
    push_beat(1'b1, 1, 16'hD001, 1'b1);
    run_scenario("after_wd");

    // Randomized bursts, some longer than MAX_BURST.
    for (int r = 0; r < 6; r++) begin
      for (int who = 0; who < 2; who++) begin
        int nb;
        nb = int'($urandom_range(0, 3));
        for (int b = 0; b < nb; b++) begin
          int len;
          len = int'($urandom_range(1, 12));
          for (int k = 0; k < len; k++)
            push_beat(who != 0, int'($urandom_range(0, 7)), int'($urandom & 32'hFFFF), k == len - 1);
        end
      end
      run_scenario("random");
    end

    // Top up to a multiple of 256 beats so wr_count wraps to 0.
    rem = (256 - (m_total % 256)) % 256;
    for (int k = 0; k < rem; k++)
      push_beat(1'b0, k % 8, k, ((k % 8) == 7) || (k == rem - 1));
    run_scenario("wrap");
    chk("wrap.count_zero", 32'(wr_count), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Two-requester, round-robin arbiter that shares the single write port (WriteEn/WriteReg/WriteData) of the 8×16 register file with max/min unit. Each requester issues bursts of single-beat writes under a req/ack handshake. The arbiter grants one requester per burst and registers the winning beat onto the register-file write port. It sits directly in front of the register file and is the only driver of its write inputs.

## Interface
Parameters:
- DATA_W, 16, write data width
- ADDR_W, 3, register address width (8 entries)
- MAX_BURST, 8, maximum beats per grant before forced release (1..15)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  write request, held high until the beat is acked
- last0 / last1  in  1  marks the current beat as the final beat of the burst
- addr0 / addr1  in  ADDR_W  target register of the current beat
- data0 / data1  in  DATA_W  write data of the current beat
- ack0 / ack1  out  1  beat accepted this cycle (combinational)
- WriteEn  out  1  register-file write enable (registered)
- WriteReg  out  ADDR_W  register-file write address (registered)
- WriteData  out  DATA_W  register-file write data (registered)
- busy  out  1  state ≠ IDLE
- owner  out  1  current or last granted requester (0/1)
- wr_count  out  8  total beats issued to the register file, wraps 255→0

## Operation
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- States: IDLE, GRANT0, GRANT1. There is a priority pointer `ptr`, reset to 0.
- IDLE:
  - With no req, stay in IDLE.
  - With only reqN high, go to GRANTN.
  - With both high, go to GRANT[ptr].
  - owner updates on entry to GRANTN.
- GRANTN:
  - ackN = reqN. ackM (the other requester) = 0. No acks are asserted in IDLE.
  - Beat accepted (reqN & ackN): on the next edge, WriteEn←1, WriteReg←addrN, WriteData←dataN. beat_cnt increments. wr_count increments.
  - No beat this cycle: WriteEn←0 on the next edge. WriteReg and WriteData hold their values.
- Burst end: the arbiter goes to IDLE on the next edge and sets ptr←~N when any of these occurs in GRANTN:
  - an accepted beat with lastN = 1;
  - an accepted beat that makes beat_cnt = MAX_BURST (forced release; the beat is still written);
  - reqN = 0 (requester withdrew; no beat).
- beat_cnt clears on entry to any GRANT state.
- Requester rules: addrN and dataN must be stable while reqN is high. A requester may keep reqN high across bursts; it then re-arbitrates in IDLE with the other requester having priority.
- Simultaneous events: both requests in IDLE resolve by ptr only. A request arriving for the non-owner during a grant waits; the owner is never preempted except by MAX_BURST.
- No address checking: every ADDR_W value is legal. Back-to-back writes to the same address are both issued in order.

## Timing
- Reset values: state IDLE, ptr 0, owner 0, busy 0, ack0/ack1 0, WriteEn 0, WriteReg 0, WriteData 0, beat_cnt 0, wr_count 0.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronous), so WriteEn drops without waiting for an edge. The in-flight beat is lost.
- Request-to-write latency:
  - reqN rises before edge E0.
  - GRANTN is entered at E0, and ackN is high in the cycle after E0.
  - WriteEn is high after E1, and the register file captures the beat at E2.
- Throughput: one beat per cycle within a burst.
- Burst handoff: exactly one IDLE cycle (no ack) between consecutive bursts.
- WriteEn is high only in cycles following an accepted beat. A MAX_BURST=8 burst therefore gives 8 consecutive WriteEn cycles.
- wr_count wraps modulo 256 with no saturation.

## Test plan
- Reset:
  - Assert rst_n=0 mid-burst → WriteEn, ack0/ack1, busy, wr_count read 0 with no clock edge.
  - Release reset → state IDLE, ptr 0.
- Single burst, requester 0:
  - Stimulus: req0 with addr 0..7 / data 0..7, last0 on the 8th beat.
  - Response: WriteEn high for 8 consecutive cycles with WriteReg/WriteData = 0/0 … 7/7. The first write lands 2 edges after the req0-sampled edge. wr_count=8, then busy=0.
- Contention:
  - Stimulus: req0 and req1 rise together after reset, each sending 2-beat bursts (req0: addr 1/data 0x00AA, addr 2/data 0x00BB; req1: addr 3/data 0x1111, addr 4/data 0x2222).
  - Response: requester 0 writes first, then one idle cycle, then requester 1 writes. owner goes 0→1, ptr returns to 0.
- Forced release:
  - Stimulus: req1 held high with last1=0 for 12 beats while req0 is waiting.
  - Response: exactly 8 requester-1 beats, then requester 0 is granted, then requester 1 is granted again for its remaining 4 beats.
- Withdrawal:
  - Stimulus: req0 drops after 3 beats without last0.
  - Response: 3 writes issued, then state IDLE and ptr=1.
- Counter wrap: 256 total beats → wr_count reads 0.
